// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word width, I/O window base and the MMIO queue entry layout.
package cpu_pkg;

   localparam int          WORD_W            = 16;
   localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;

   typedef struct packed {
      logic [7:0]        offset;
      logic [WORD_W-1:0] data;
   } mmio_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; EMPTY/PARTIAL/FULL control state tracks the count.
//
// state      | meaning
// -----------+------------------------------------------
// ST_EMPTY   | no entries, head invalid
// ST_PARTIAL | 1..DEPTH-1 entries
// ST_FULL    | DEPTH entries, push only legal with a pop
module sync_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = mmio_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rst_b_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  entry_t                   wdata_i,
   output logic                     full_o,
   output logic                     empty_o,
   output entry_t                   head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LAST_FREE = CW'(DEPTH - 1);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [1:0]      state_q, state_d;
   logic            push_ok, pop_ok;

   assign pop_ok  = pop_i && (state_q != ST_EMPTY);
   assign push_ok = push_i && ((state_q != ST_FULL) || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      case (state_q)
         ST_EMPTY:   if (push_ok && !pop_ok) state_d = ST_PARTIAL;
         ST_PARTIAL: begin
            if (push_ok && !pop_ok && count_q == LAST_FREE)     state_d = ST_FULL;
            else if (pop_ok && !push_ok && count_q == CW'(1))   state_d = ST_EMPTY;
         end
         ST_FULL:    if (pop_ok && !push_ok) state_d = ST_PARTIAL;
         default:    state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_EMPTY;
         // Cleared so the head reads as zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign full_o  = (state_q == ST_FULL);
   assign empty_o = (state_q == ST_EMPTY);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/mmio_store_queue.sv
// Diverts memory-stage stores that hit the I/O window into a FIFO drained over valid/ready;
// stalls the pipeline when a hit finds the FIFO full with no pop this cycle.
module mmio_store_queue
   import cpu_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write_memory_enable_memory,
   input  logic [WORD_W-1:0]       srcA_memory,
   input  logic [WORD_W-1:0]       srcB_memory,
   output logic                    ram_wren,
   output logic                    stall,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              out_offset,
   output logic [WORD_W-1:0]       out_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic [15:0]             store_total
);

   logic        hit, push, pop, full, empty;
   logic [15:0] store_total_q, store_total_d;
   mmio_entry_t wr_entry, head;

   assign hit = write_memory_enable_memory && (srcA_memory[15:8] == MMIO_BASE[15:8]);
   assign pop = out_valid && out_ready;

   // Reset gates the combinational pipeline controls so nothing leaks out while held.
   assign push     = reset && hit && (!full || pop);
   assign stall    = reset && hit && full && !pop;
   assign ram_wren = reset && write_memory_enable_memory && !hit;

   assign wr_entry = '{offset: srcA_memory[7:0], data: srcB_memory};

   sync_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (mmio_entry_t)
   ) u_fifo (
      .clk_i   (clk),
      .rst_b_i (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head),
      .count_o (count)
   );

   assign store_total_d = push ? store_total_q + 16'd1 : store_total_q;

   always_ff @(posedge clk) begin
      if (!reset) store_total_q <= '0;
      else        store_total_q <= store_total_d;
   end

   assign out_valid   = !empty;
   assign out_offset  = head.offset;
   assign out_data    = head.data;
   assign store_total = store_total_q;

endmodule
